// File: rtl/hdr_merge_pkg.sv
// Shared definitions for the HDR merge stage: FSM encoding, default widths and exposure shifts,
// and a helper that finds the largest normalising shift.
package hdr_merge_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam int unsigned PixWDef   = 6;
  localparam int unsigned WWDef     = 12;
  localparam int unsigned OutWDef   = 10;
  localparam int unsigned ShHighDef = 0;
  localparam int unsigned ShMidDef  = 2;
  localparam int unsigned ShLowDef  = 4;

  function automatic int unsigned max_shift(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/hdr_merge_if.sv
// Input-triple and output-sample handshake bundle for hdr_merge.
// master drives the exposures and out_ready; slave (the merge stage) drives the result.
interface hdr_merge_if
  import hdr_merge_pkg::*;
#(
  parameter int unsigned PIX_W = PixWDef,
  parameter int unsigned W_W   = WWDef,
  parameter int unsigned OUT_W = OutWDef
);

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] pixel_high;
  logic [PIX_W-1:0] pixel_mid;
  logic [PIX_W-1:0] pixel_low;
  logic [W_W-1:0]   w_high;
  logic [W_W-1:0]   w_mid;
  logic [W_W-1:0]   w_low;
  logic [OUT_W-1:0] hdr_pixel;
  logic             out_valid;
  logic             out_ready;
  logic             zero_div;

  modport master (
    output in_valid,
    output pixel_high,
    output pixel_mid,
    output pixel_low,
    output w_high,
    output w_mid,
    output w_low,
    output out_ready,
    input  in_ready,
    input  hdr_pixel,
    input  out_valid,
    input  zero_div
  );

  modport slave (
    input  in_valid,
    input  pixel_high,
    input  pixel_mid,
    input  pixel_low,
    input  w_high,
    input  w_mid,
    input  w_low,
    input  out_ready,
    output in_ready,
    output hdr_pixel,
    output out_valid,
    output zero_div
  );

endinterface

// File: rtl/hdr_merge_seq_div.sv
// Bit-serial unsigned restoring divider: start loads operands, then one quotient bit per cycle,
// MSB first, for NUM_W cycles. done_o/quot_o present the final step combinationally.
module hdr_merge_seq_div #(
  parameter int unsigned NUM_W = 24,
  parameter int unsigned DEN_W = 14,
  parameter int unsigned Q_W   = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [Q_W-1:0]   quot_o
);

  localparam int unsigned CntW = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  logic             busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NUM_W-1:0] dvd_q, dvd_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;

  logic [DEN_W:0]   rem_sh;
  logic             ge;
  logic [DEN_W-1:0] rem_step;
  logic [NUM_W-1:0] dvd_step;

  // Dividend shifts out MSB-first while quotient bits shift in at the bottom of the same register.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[NUM_W-1]};
    ge       = (rem_sh >= {1'b0, den_q});
    rem_step = ge ? DEN_W'(rem_sh - {1'b0, den_q}) : rem_sh[DEN_W-1:0];
    dvd_step = {dvd_q[NUM_W-2:0], ge};
  end

  assign done_o = busy_q && (cnt_q == CntW'(NUM_W - 1));
  assign quot_o = dvd_step[Q_W-1:0];

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    den_d  = den_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      dvd_d  = num_i;
      rem_d  = '0;
      den_d  = den_i;
    end else if (busy_q) begin
      dvd_d = dvd_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 1'b1;
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
    end
  end

endmodule

// File: rtl/hdr_merge.sv
// HDR merge: weighted average of exposure-normalised pixels, divided by the weight sum.
// Optional HDR_MERGE_ROUND_EN: bias the numerator by den/2 for round-to-nearest (ties up).
module hdr_merge
  import hdr_merge_pkg::*;
#(
  parameter int unsigned PIX_W   = PixWDef,
  parameter int unsigned W_W     = WWDef,
  parameter int unsigned SH_HIGH = ShHighDef,
  parameter int unsigned SH_MID  = ShMidDef,
  parameter int unsigned SH_LOW  = ShLowDef,
  parameter int unsigned OUT_W   = OutWDef
) (
  input logic        clk,
  input logic        rst_n,
  hdr_merge_if.slave bus
);

  localparam int unsigned SH_MAX = max_shift(SH_HIGH, SH_MID, SH_LOW);
  localparam int unsigned SP_W   = PIX_W + SH_MAX;
  localparam int unsigned NUM_W  = W_W + SP_W + 2;
  localparam int unsigned DEN_W  = W_W + 2;

  logic [1:0]       state_q, state_d;
  logic [PIX_W-1:0] pix_h_q, pix_m_q, pix_l_q;
  logic [W_W-1:0]   w_h_q, w_m_q, w_l_q;
  logic [OUT_W-1:0] hdr_q, hdr_d;
  logic             out_valid_q, out_valid_d;
  logic             zd_q, zd_d;

  logic             accept;
  logic [NUM_W-1:0] mac_sum;
  logic [NUM_W-1:0] num_d;
  logic [DEN_W-1:0] den_d;
  logic [OUT_W-1:0] zd_pix;
  logic             div_start;
  logic             div_done;
  logic [NUM_W-1:0] div_quot;
  logic             sat;

  assign accept       = bus.in_valid && (state_q == StIdle);
  assign bus.in_ready = (state_q == StIdle);
  assign bus.hdr_pixel = hdr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.zero_div  = zd_q;

  always_comb begin
    mac_sum = NUM_W'(w_h_q) * (NUM_W'(pix_h_q) << SH_HIGH)
            + NUM_W'(w_m_q) * (NUM_W'(pix_m_q) << SH_MID)
            + NUM_W'(w_l_q) * (NUM_W'(pix_l_q) << SH_LOW);
    den_d   = DEN_W'(w_h_q) + DEN_W'(w_m_q) + DEN_W'(w_l_q);
`ifdef HDR_MERGE_ROUND_EN
    num_d   = mac_sum + NUM_W'(den_d >> 1);
`else
    num_d   = mac_sum;
`endif
    zd_pix  = OUT_W'(pix_m_q) << SH_MID;
  end

  // The divider registers num/den itself while the FSM sits in MAC.
  assign div_start = (state_q == StMac) && (den_d != '0);

  hdr_merge_seq_div #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W),
    .Q_W   (NUM_W)
  ) u_div (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (div_start),
    .num_i   (num_d),
    .den_i   (den_d),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  assign sat = |div_quot[NUM_W-1:OUT_W];

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    out_valid_d = out_valid_q;
    zd_d        = zd_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) state_d = StMac;
      end
      StMac: begin
        if (den_d == '0) begin
          hdr_d   = zd_pix;
          zd_d    = 1'b1;
          state_d = StDone;
        end else begin
          zd_d    = 1'b0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (div_done) begin
          hdr_d       = sat ? '1 : div_quot[OUT_W-1:0];
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        // Zero-den entry arrives with out_valid low; it is raised one cycle later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hdr_q       <= '0;
      out_valid_q <= 1'b0;
      zd_q        <= 1'b0;
      pix_h_q     <= '0;
      pix_m_q     <= '0;
      pix_l_q     <= '0;
      w_h_q       <= '0;
      w_m_q       <= '0;
      w_l_q       <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      out_valid_q <= out_valid_d;
      zd_q        <= zd_d;
      if (accept) begin
        pix_h_q <= bus.pixel_high;
        pix_m_q <= bus.pixel_mid;
        pix_l_q <= bus.pixel_low;
        w_h_q   <= bus.w_high;
        w_m_q   <= bus.w_mid;
        w_l_q   <= bus.w_low;
      end
    end
  end

endmodule
